// File: rtl/mem_bridge_pkg.sv
// Shared types for the MIPS data-memory bridge:
// access size codes, FSM states, wait counter width.
package mem_bridge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = $clog2(16);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Size 11 behaves as a word everywhere.
  function automatic logic [1:0] align_lo(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    unique case (1'b1)
      size == SZ_BYTE: align_lo = lo;
      size == SZ_HALF: align_lo = {lo[1], 1'b0};
      default:         align_lo = 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    misaligned = (size == SZ_HALF && lo[0]) ||
                 (size[1] && lo != 2'b00);
  endfunction

endpackage

// File: rtl/mips_mem_lane.sv
// Byte-lane steering: store enables/replication,
// load lane select with sign/zero extension.
module mips_mem_lane
  import mem_bridge_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ram_rdata,
  output logic [3:0]  be,
  output logic [31:0] st_word,
  output logic [31:0] ld_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = 8'(ram_rdata >> {lo, 3'b000});
    ld_half = lo[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    be      = 4'b1111;
    st_word = st_data;
    ld_word = ram_rdata;
    unique case (1'b1)
      size == SZ_BYTE: begin
        be      = 4'b0001 << lo;
        st_word = {4{st_data[7:0]}};
        ld_word = {{24{sign & ld_byte[7]}}, ld_byte};
      end
      size == SZ_HALF: begin
        be      = lo[1] ? 4'b1100 : 4'b0011;
        st_word = {2{st_data[15:0]}};
        ld_word = {{16{sign & ld_half[15]}}, ld_half};
      end
      default: begin
        be = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/mips_mem_bridge.sv
// Core load/store port to word-wide sync RAM bridge.
// Define MEM_BRIDGE_MISALIGN_EN to trap misaligned accesses.
module mips_mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int RAM_AW      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [1:0]        core_size,
  input  logic              core_sign,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              core_ready,
  output logic              core_stall,
  output logic              core_err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [CNT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, sign_q, err_q;
  logic [1:0]        size_q, lo_q;
  logic [RAM_AW-1:0] waddr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic              accept, mis;
  logic [3:0]        be;
  logic [31:0]       st_word, ld_word;

  assign accept = core_req &&
                  (state_q == S_IDLE || state_q == S_RESP);

`ifdef MEM_BRIDGE_MISALIGN_EN
  assign mis = misaligned(core_size, core_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) state_d = mis ? S_RESP : S_ISSUE;
        else        state_d = S_IDLE;
      end
      S_ISSUE: begin
        cnt_d   = WAIT_INIT;
        state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      lo_q    <= 2'b00;
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= core_we;
        sign_q  <= core_sign;
        size_q  <= core_size;
        lo_q    <= align_lo(core_size, core_addr[1:0]);
        waddr_q <= core_addr[RAM_AW+1:2];
        wdata_q <= core_wdata;
        err_q   <= mis;
      end
      // Load result is captured as RESP ends.
      if (state_q == S_RESP && !we_q && !err_q)
        rdata_q <= ld_word;
    end
  end

  mips_mem_lane u_lane (
    .size      (size_q),
    .sign      (sign_q),
    .lo        (lo_q),
    .st_data   (wdata_q),
    .ram_rdata (ram_rdata),
    .be        (be),
    .st_word   (st_word),
    .ld_word   (ld_word)
  );

  assign ram_en     = (state_q == S_ISSUE);
  assign ram_we     = (ram_en && we_q) ? be : 4'b0000;
  assign ram_addr   = ram_en ? waddr_q : '0;
  assign ram_wdata  = ram_en ? st_word : '0;
  assign core_ready = (state_q == S_RESP);
  assign core_stall = (state_q == S_ISSUE) ||
                      (state_q == S_WAIT);
  assign core_rdata = rdata_q;

`ifdef MEM_BRIDGE_MISALIGN_EN
  assign core_err = core_ready && err_q;
`else
  assign core_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mem_bridge.sv
// Scoreboard bench for mips_mem_bridge with a
// byte-addressed shadow memory as reference.
module tb_mips_mem_bridge;

  localparam int W  = 3;
  localparam int AW = 10;
  localparam int NB = 4 << AW;
`ifdef MEM_BRIDGE_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          core_req = 1'b0;
  logic          core_we = 1'b0;
  logic [1:0]    core_size = 2'b00;
  logic          core_sign = 1'b0;
  logic [31:0]   core_addr = '0;
  logic [31:0]   core_wdata = '0;
  logic [31:0]   core_rdata;
  logic          core_ready, core_stall, core_err;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = '0;

  always #5 clk = ~clk;

  mips_mem_bridge #(
    .ADDR_W(32), .RAM_AW(AW), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we),
    .core_size(core_size), .core_sign(core_sign),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ready(core_ready),
    .core_stall(core_stall), .core_err(core_err),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  typedef struct {
    bit            we;
    bit            err;
    logic [31:0]   rdata;
    int            en_cyc;
    int            rdy_cyc;
    logic [AW-1:0] waddr;
    logic [3:0]    be;
    logic [31:0]   wd;
  } item_t;

  item_t       cmd_q[$];
  item_t       rsp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_rdata = '0;
  bit          rd_pend = 0;
  logic [31:0] rd_exp = '0;
  bit          prev_en = 0;

  logic [31:0] ram [1<<AW];
  logic [7:0]  shadow [NB];
  logic [31:0] pend = '0;
  int          dly = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM with WAIT_CYCLES latency; junk on the bus until data is due.
  always @(posedge clk) begin
    logic [31:0] nw;
    if (ram_en) begin
      nw = ram[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) nw[8*b +: 8] = ram_wdata[8*b +: 8];
      ram[ram_addr] <= nw;
      pend <= ram[ram_addr];
      if (W == 0) ram_rdata <= ram[ram_addr];
      else        ram_rdata <= $urandom;
      dly <= W;
    end else if (dly > 0) begin
      if (dly == 1) ram_rdata <= pend;
      dly <= dly - 1;
    end
  end

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic int ebase(logic [1:0] s, logic [31:0] a);
    int n = nbytes(s);
    return (int'(a & (NB - 1)) / n) * n;
  endfunction

  function automatic logic [31:0] model_load(
    logic [1:0] s, bit sg, logic [31:0] a);
    int n = nbytes(s);
    int base = ebase(s, a);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = shadow[base + i];
    if (sg && n < 4 && v[8*n-1])
      for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit model_mis(logic [1:0] s, logic [31:0] a);
    return MIS_EN && ((int'(a[1:0]) % nbytes(s)) != 0);
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic access(bit we, logic [1:0] s, bit sg,
                        logic [31:0] a, logic [31:0] wd,
                        bit use_c, logic [31:0] cval);
    item_t it;
    int n = 0;
    int nb, base;
    core_req = 1'b1; core_we = we; core_size = s;
    core_sign = sg; core_addr = a; core_wdata = wd;
    while (core_stall && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 50), 32'd1);
    nb = nbytes(s);
    base = ebase(s, a);
    it.we = we;
    it.err = model_mis(s, a);
    it.en_cyc = cyc + 1;
    it.rdy_cyc = it.err ? cyc + 1 : cyc + 2 + W;
    it.waddr = AW'(base >> 2);
    it.be = we ? 4'(((1 << nb) - 1) << (base % 4)) : 4'b0000;
    it.wd = (nb == 1) ? {4{wd[7:0]}} :
            (nb == 2) ? {2{wd[15:0]}} : wd;
    it.rdata = '0;
    if (!it.err) begin
      if (!we) it.rdata = use_c ? cval : model_load(s, sg, a);
      else
        for (int i = 0; i < nb; i++) shadow[base + i] = wd[8*i +: 8];
      cmd_q.push_back(it);
    end
    rsp_q.push_back(it);
    @(posedge clk);
    @(negedge clk);
    core_req = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_rdata"}, core_rdata, 32'h0);
    check({tag, "_ready"}, 32'(core_ready), 32'h0);
    check({tag, "_stall"}, 32'(core_stall), 32'h0);
    check({tag, "_err"}, 32'(core_err), 32'h0);
    check({tag, "_en"}, 32'(ram_en), 32'h0);
    check({tag, "_we"}, 32'(ram_we), 32'h0);
    check({tag, "_addr"}, 32'(ram_addr), 32'h0);
    check({tag, "_wdata"}, ram_wdata, 32'h0);
  endtask

  // Monitor: compares whatever the DUT presents against queue heads.
  always @(negedge clk) begin
    item_t it;
    bit exp_stall;
    if (rst) begin
      if (rd_pend) begin
        check("rdata", core_rdata, rd_exp);
        rd_pend = 0;
      end
      exp_stall = rsp_q.size() > 0 && cyc >= rsp_q[0].en_cyc &&
                  cyc < rsp_q[0].rdy_cyc;
      check("stall", 32'(core_stall), 32'(exp_stall));
      if (ram_en) begin
        check("en_back_to_back", 32'(prev_en), 32'h0);
        if (cmd_q.size() == 0) begin
          check("unexpected_ram_en", 32'h1, 32'h0);
        end else begin
          it = cmd_q.pop_front();
          check("en_cycle", cyc, it.en_cyc);
          check("ram_addr", 32'(ram_addr), 32'(it.waddr));
          check("ram_we", 32'(ram_we), 32'(it.be));
          if (it.we) check("ram_wdata", ram_wdata, it.wd);
        end
      end
      prev_en = ram_en;
      if (core_ready) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_ready", 32'h1, 32'h0);
        end else begin
          it = rsp_q.pop_front();
          check("ready_cycle", cyc, it.rdy_cyc);
          check("err", 32'(core_err), 32'(it.err));
          if (!it.we && !it.err) last_rdata = it.rdata;
          rd_exp = last_rdata;
          rd_pend = 1;
        end
      end else begin
        check("err_idle", 32'(core_err), 32'h0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    int n;
    for (int w = 0; w < (1 << AW); w++) begin
      v = $urandom;
      ram[w] = v;
      for (int b = 0; b < 4; b++) shadow[4*w + b] = v[8*b +: 8];
    end
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    access(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0);
    access(1, 2'b10, 0, 32'h10, 32'h80FF1234, 0, 0);
    access(0, 2'b00, 1, 32'h13, 0, 1, 32'hFFFFFF80);
    access(0, 2'b00, 0, 32'h13, 0, 1, 32'h00000080);
    access(0, 2'b01, 1, 32'h12, 0, 1, 32'hFFFF80FF);
    access(0, 2'b10, 0, 32'h10, 0, 1, 32'h80FF1234);
    access(1, 2'b01, 0, 32'h06, 32'h0000ABCD, 0, 0);
    access(0, 2'b10, 0, 32'h04, 0, 0, 0);
    access(0, 2'b10, 0, 32'h02, 0, 0, 0);
    access(0, 2'b11, 1, 32'hFFFF_F010, 0, 0, 0);
    repeat (3) @(negedge clk);

    access(0, 2'b10, 0, 32'h20, 0, 0, 0);
    @(posedge clk);
    #1 check("stall_in_wait", 32'(core_stall), 32'h1);
    #1 rst = 1'b0;
    #1 check_all_zero("mid_reset");
    cmd_q.delete();
    rsp_q.delete();
    rd_pend = 0;
    prev_en = 0;
    last_rdata = '0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    access(0, 2'b00, 1, 32'h13, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'h3F;
      access(1'($urandom), 2'($urandom), 1'($urandom), a,
             $urandom, 0, 0);
      if ($urandom_range(0, 1) == 0)
        repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while ((rsp_q.size() > 0 || rd_pend) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_rsp", 32'(rsp_q.size()), 32'h0);
    check("drain_cmd", 32'(cmd_q.size()), 32'h0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
